// File: rtl/lsu_mem_port_if.sv
// Memory bus between the load/store unit (master) and the data memory (slave).
interface lsu_mem_port_if;
    logic        mem_req;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store unit memory port: accepts one pipeline access at a time, drives a
// req/gnt + rvalid memory bus, lane-shifts stores and extends loads.
// Optional: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses
// (no bus request, one-cycle misalign_err pulse) instead of issuing them.
module lsu_mem_port (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic                  dmemen,
    input  logic [3:0]            dmemwe,
    input  logic [3:0]            LD_sel,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic                  stall,
    output logic [31:0]           rdata,
    output logic                  rdata_valid,
    output logic                  misalign_err,
    lsu_mem_port_if.master        bus
);

    typedef enum logic [1:0] {StIdle, StReq, StWaitR, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic        load_q, load_d;
    logic [3:0]  ld_sel_q, ld_sel_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;

    logic        accept;
    logic        is_load_in;
    logic [2:0]  size_in;
    logic        noop_in;
    logic        mis_in;
    logic [7:0]  we_shift;
    logic [31:0] rd_shift;
    logic [31:0] rd_ext;

    // Decode access size of the presented instruction; 0 marks an unsupported code.
    always_comb begin
        is_load_in = (dmemwe == 4'b0000);
        size_in    = 3'd0;
        if (is_load_in) begin
            case (LD_sel)
                4'b0001, 4'b0101: size_in = 3'd1;
                4'b0011, 4'b0111: size_in = 3'd2;
                4'b1111:          size_in = 3'd4;
                default:          size_in = 3'd0;
            endcase
        end else begin
            case (dmemwe)
                4'b0001: size_in = 3'd1;
                4'b0011: size_in = 3'd2;
                4'b1111: size_in = 3'd4;
                default: size_in = 3'd0;
            endcase
        end
        noop_in = (size_in == 3'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        mis_in = ((size_in == 3'd2) && addr[0]) || ((size_in == 3'd4) && (addr[1:0] != 2'b00));
`else
        mis_in = 1'b0;
`endif
        we_shift = {4'b0000, dmemwe} << addr[1:0];
    end

    // Pick the addressed byte/half out of the returned word and extend it.
    always_comb begin
        rd_shift = bus.mem_rdata >> {off_q, 3'b000};
        case (ld_sel_q)
            4'b0001: rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            4'b0011: rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            4'b1111: rd_ext = rd_shift;
            4'b0101: rd_ext = {24'h000000, rd_shift[7:0]};
            4'b0111: rd_ext = {16'h0000, rd_shift[15:0]};
            default: rd_ext = 32'h0000_0000;
        endcase
    end

    assign accept = (state_q == StIdle) && valid && dmemen;

    // Next-state and datapath latching.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        load_d   = load_q;
        ld_sel_d = ld_sel_q;
        off_d    = off_q;
        rdata_d  = rdata_q;
        mis_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d   = {addr[31:2], 2'b00};
                    we_d     = (is_load_in || noop_in || mis_in) ? 4'b0000 : we_shift[3:0];
                    wdata_d  = wdata << {addr[1:0], 3'b000};
                    load_d   = is_load_in;
                    ld_sel_d = LD_sel;
                    off_d    = addr[1:0];
                    mis_d    = mis_in;
                    if (noop_in) begin
                        rdata_d = 32'h0000_0000;
                        state_d = StDone;
                    end else if (mis_in) begin
                        state_d = StDone;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                // rvalid arriving together with gnt belongs to nothing yet.
                if (bus.mem_gnt) begin
                    state_d = load_q ? StWaitR : StDone;
                end
            end
            StWaitR: begin
                if (bus.mem_rvalid) begin
                    rdata_d = rd_ext;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= 32'h0000_0000;
            we_q     <= 4'b0000;
            wdata_q  <= 32'h0000_0000;
            load_q   <= 1'b0;
            ld_sel_q <= 4'b0000;
            off_q    <= 2'b00;
            rdata_q  <= 32'h0000_0000;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            load_q   <= load_d;
            ld_sel_q <= ld_sel_d;
            off_q    <= off_d;
            rdata_q  <= rdata_d;
            mis_q    <= mis_d;
        end
    end

    // A trapped access reaches DONE exactly in its misalign_err cycle, so that pulse
    // also suppresses rdata_valid.
    assign stall = !rst && (accept || (state_q == StReq) || (state_q == StWaitR));
    assign bus.mem_req   = !rst && (state_q == StReq);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign rdata         = rdata_q;
    assign misalign_err  = mis_q;
    assign rdata_valid   = (state_q == StDone) && load_q && !mis_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: a byte-level reference memory predicts bus
// transfers and load results, a bus responder models the memory with random delays.
module tb_lsu_mem_port;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, dmemen;
    logic [3:0]  dmemwe, ld_sel;
    logic [31:0] addr, wdata;
    logic        stall, rdata_valid, misalign_err;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    lsu_mem_port_if bus_if ();

    lsu_mem_port dut (
        .clk          (clk),
        .rst          (rst),
        .valid        (valid),
        .dmemen       (dmemen),
        .dmemwe       (dmemwe),
        .LD_sel       (ld_sel),
        .addr         (addr),
        .wdata        (wdata),
        .stall        (stall),
        .rdata        (rdata),
        .rdata_valid  (rdata_valid),
        .misalign_err (misalign_err),
        .bus          (bus_if)
    );

    typedef struct {
        logic [31:0] a;
        logic [3:0]  we;
        logic [31:0] wd;
    } bus_t;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  bmem [256];
    logic [7:0]  mmem [256];
    bus_t        exp_bus [$];
    logic [31:0] exp_rd [$];
    int          gnt_delay = 0;
    int          rv_delay  = 0;
    logic [31:0] hold = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] we);
        logic [31:0] m;
        m = 32'h0;
        for (int b = 0; b < 4; b++) if (we[b]) m[8*b +: 8] = 8'hFF;
        return m;
    endfunction

    // Monitor: compare bus requests and load completions against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus_if.mem_req) begin
                    if (exp_bus.size() == 0) begin
                        check("unexpected_mem_req", 32'(bus_if.mem_req), 32'h0);
                    end else begin
                        check("mem_addr", bus_if.mem_addr, exp_bus[0].a);
                        check("mem_we", 32'(bus_if.mem_we), 32'(exp_bus[0].we));
                        check("mem_wdata", bus_if.mem_wdata & lane_mask(exp_bus[0].we),
                              exp_bus[0].wd);
                        if (bus_if.mem_gnt) void'(exp_bus.pop_front());
                    end
                end
                if (rdata_valid) begin
                    if (exp_rd.size() == 0) check("unexpected_rdata_valid", 32'(rdata_valid), 0);
                    else check("rdata", rdata, exp_rd.pop_front());
                end
            end
        end
    end

    // Bus responder: gnt after gnt_delay cycles, rvalid rv_delay cycles after gnt,
    // plus spurious gnt/rvalid whenever they must be ignored.
    initial begin
        bit          hs, in_req, pend;
        logic [3:0]  hw;
        logic [31:0] ha, hd, raddr;
        int          gcnt, rwait;
        in_req = 0; pend = 0; gcnt = 0; rwait = 0; raddr = 0;
        bus_if.mem_gnt = 1'b0; bus_if.mem_rvalid = 1'b0; bus_if.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            hs = bus_if.mem_req && bus_if.mem_gnt;
            hw = bus_if.mem_we; ha = bus_if.mem_addr; hd = bus_if.mem_wdata;
            @(posedge clk);
            #1;
            if (hs) begin
                in_req = 0;
                if (hw == 4'b0000) begin
                    pend = 1; rwait = rv_delay; raddr = ha;
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (hw[b]) bmem[(ha + b) & 255] = hd[8*b +: 8];
                end
            end
            bus_if.mem_rvalid = 1'b0;
            bus_if.mem_rdata  = $urandom;
            if (pend) begin
                if (rwait == 0) begin
                    bus_if.mem_rvalid = 1'b1;
                    bus_if.mem_rdata  = {bmem[(raddr + 3) & 255], bmem[(raddr + 2) & 255],
                                         bmem[(raddr + 1) & 255], bmem[raddr & 255]};
                    pend = 0;
                end else begin
                    rwait--;
                end
            end else if (bus_if.mem_req || $urandom_range(0, 3) == 0) begin
                bus_if.mem_rvalid = 1'b1;
            end
            if (bus_if.mem_req) begin
                if (!in_req) begin
                    in_req = 1; gcnt = gnt_delay;
                end
                bus_if.mem_gnt = (gcnt == 0);
                if (gcnt > 0) gcnt--;
            end else begin
                in_req = 0;
                bus_if.mem_gnt = ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Issue one access, predict its effect from the reference memory, wait for completion.
    task automatic do_op(input logic [3:0] we_i, input logic [3:0] ls_i,
                         input logic [31:0] a_i, input logic [31:0] wd_i, output int cyc);
        bit          is_ld, sgn, mis, exp_rv, done;
        int          size, off, lane;
        logic [31:0] exp_val, base;
        bus_t        ent;
        is_ld = (we_i == 4'b0000);
        sgn   = 0;
        size  = 0;
        if (is_ld) begin
            case (ls_i)
                4'b0001: begin size = 1; sgn = 1; end
                4'b0011: begin size = 2; sgn = 1; end
                4'b1111: size = 4;
                4'b0101: size = 1;
                4'b0111: size = 2;
                default: size = 0;
            endcase
        end else begin
            case (we_i)
                4'b0001: size = 1;
                4'b0011: size = 2;
                4'b1111: size = 4;
                default: size = 0;
            endcase
        end
        off     = int'(a_i[1:0]);
        mis     = TrapEn && ((size == 2 && off % 2 == 1) || (size == 4 && off != 0));
        exp_rv  = is_ld && !mis;
        exp_val = 32'h0;
        if (size != 0 && !mis) begin
            base   = a_i - 32'(off);
            ent.a  = base; ent.we = 4'b0000; ent.wd = 32'h0;
            for (int i = 0; i < size; i++) begin
                lane = off + i;
                if (lane < 4) begin
                    if (is_ld) begin
                        exp_val[8*i +: 8] = mmem[(base + 32'(lane)) & 255];
                    end else begin
                        ent.we[lane]        = 1'b1;
                        ent.wd[8*lane +: 8] = wd_i[8*i +: 8];
                        mmem[(base + 32'(lane)) & 255] = wd_i[8*i +: 8];
                    end
                end
            end
            if (sgn && exp_val[8*size-1]) exp_val = exp_val | (32'hFFFF_FFFF << (8 * size));
            exp_bus.push_back(ent);
        end
        if (exp_rv) exp_rd.push_back(exp_val);

        @(posedge clk);
        #1;
        valid = 1'b1; dmemen = 1'b1; dmemwe = we_i; ld_sel = ls_i; addr = a_i; wdata = wd_i;
        cyc  = 0;
        done = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (!stall) done = 1;
            else cyc++;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL op_timeout: stall still high after 300 cycles, want completion");
        end
        check("done_rdata_valid", 32'(rdata_valid), 32'(exp_rv));
        check("done_misalign_err", 32'(misalign_err), 32'(mis));
        if (!exp_rv) check("rdata_hold", rdata, (size == 0) ? 32'h0 : hold);
        if (exp_rv) hold = exp_val;
        else if (size == 0) hold = 32'h0;
        @(posedge clk);
        #1;
        valid = 1'b0; dmemen = 1'b0; addr = $urandom; wdata = $urandom;
    endtask

    initial begin
        int          cyc, diff;
        logic [3:0]  we_tab [7];
        logic [3:0]  ls_tab [6];
        logic [3:0]  r_we;
        bit          rv_seen, st_seen;
        we_tab = '{4'b0001, 4'b0011, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0110};
        ls_tab = '{4'b0001, 4'b0011, 4'b1111, 4'b0101, 4'b0111, 4'b0000};
        for (int i = 0; i < 256; i++) begin
            bmem[i] = 8'($urandom);
            mmem[i] = bmem[i];
        end
        rst = 1'b1; valid = 1'b0; dmemen = 1'b0; dmemwe = 4'b0; ld_sel = 4'b0;
        addr = 32'h0; wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(stall), 0);
        check("rst_mem_req", 32'(bus_if.mem_req), 0);
        check("rst_mem_we", 32'(bus_if.mem_we), 0);
        check("rst_mem_addr", bus_if.mem_addr, 0);
        check("rst_mem_wdata", bus_if.mem_wdata, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rdata_valid", 32'(rdata_valid), 0);
        check("rst_misalign_err", 32'(misalign_err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Non-memory instruction must not stall.
        @(posedge clk);
        #1;
        valid = 1'b1; dmemen = 1'b0;
        @(negedge clk);
        check("nonmem_stall", 32'(stall), 0);
        check("nonmem_req", 32'(bus_if.mem_req), 0);
        @(posedge clk);
        #1;
        valid = 1'b0;

        gnt_delay = 0; rv_delay = 0;
        do_op(4'b1111, 4'b0000, 32'h104, 32'hDEAD_BEEF, cyc);
        check("lat_sw", cyc, 2);
        do_op(4'b0001, 4'b0000, 32'h203, 32'h0000_00A5, cyc);
        check("lat_sb", cyc, 2);
        bmem[0] = 8'h01; bmem[1] = 8'h7F; bmem[2] = 8'hFF; bmem[3] = 8'h80;
        for (int i = 0; i < 4; i++) mmem[i] = bmem[i];
        do_op(4'b0000, 4'b0001, 32'h2, 32'h0, cyc);
        check("lat_lb", cyc, 3);
        do_op(4'b0000, 4'b0101, 32'h3, 32'h0, cyc);
        do_op(4'b0000, 4'b0011, 32'h0, 32'h0, cyc);
        gnt_delay = 5;
        do_op(4'b1111, 4'b0000, 32'h108, 32'h1234_5678, cyc);
        check("lat_backpressure", cyc, 7);
        gnt_delay = 0;
        do_op(4'b0000, 4'b1111, 32'h102, 32'h0, cyc);
        check("lat_lw_misaligned", cyc, TrapEn ? 1 : 3);
        do_op(4'b0101, 4'b0000, 32'h40, 32'hFFFF_FFFF, cyc);
        check("lat_noop_store", cyc, 1);

        // Reset while waiting for read data: the late rvalid must be ignored.
        rv_delay = 6;
        exp_bus.push_back('{32'h10, 4'b0000, 32'h0});
        @(posedge clk);
        #1;
        valid = 1'b1; dmemen = 1'b1; dmemwe = 4'b0000; ld_sel = 4'b1111; addr = 32'h10;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1; valid = 1'b0; dmemen = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        hold = 32'h0;
        rv_seen = 0; st_seen = 0;
        repeat (10) begin
            @(negedge clk);
            rv_seen |= rdata_valid;
            st_seen |= stall;
        end
        check("rst_abandon_rdata_valid", 32'(rv_seen), 0);
        check("rst_abandon_stall", 32'(st_seen), 0);
        check("rst_abandon_rdata", rdata, 0);
        check("rst_abandon_mem_addr", bus_if.mem_addr, 0);

        for (int n = 0; n < 150; n++) begin
            gnt_delay = $urandom_range(0, 3);
            rv_delay  = $urandom_range(0, 3);
            r_we = we_tab[$urandom_range(0, 6)];
            if (n % 10 == 9) r_we = 4'($urandom);
            do_op(r_we, ls_tab[$urandom_range(0, 5)], 32'($urandom_range(0, 255)), $urandom, cyc);
        end

        repeat (8) @(negedge clk);
        check("exp_bus_drained", 32'(exp_bus.size()), 0);
        check("exp_rd_drained", 32'(exp_rd.size()), 0);
        diff = 0;
        for (int i = 0; i < 256; i++) if (bmem[i] !== mmem[i]) diff++;
        check("memory_image_diffs", 32'(diff), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 The block SHALL have these ports:
  - clk  in  1  rising-edge clock
  - rst  in  1  synchronous, active-high reset
  - valid  in  1  pipeline presents an instruction
  - dmemen  in  1  access request
  - dmemwe  in  4  store mask; 0001 SB, 0011 SH, 1111 SW, 0000 = load
  - LD_sel  in  4  load type; 0001 LB, 0011 LH, 1111 LW, 0101 LBU, 0111 LHU
  - addr  in  32  byte address
  - wdata  in  32  store data, LSB-aligned
  - stall  out  1  hold pipeline
  - rdata  out  32  extended load result
  - rdata_valid  out  1  one-cycle load-complete strobe
  - mem_req  out  1  bus request
  - mem_we  out  4  bus byte enables
  - mem_addr  out  32  word address, addr[31:2],2'b00
  - mem_wdata  out  32  lane-shifted store data
  - mem_gnt  in  1  request accepted
  - mem_rvalid  in  1  read data valid
  - mem_rdata  in  32  read word
  - misalign_err  out  1  one-cycle misaligned-access strobe
REQ-002 The block SHALL use one clock, clk; reset, rst, SHALL be synchronous and active-high.

Function
REQ-003 The FSM SHALL have states IDLE, REQ, WAIT_R, DONE.
REQ-004 In IDLE, valid&dmemen SHALL latch addr, wdata, dmemwe and LD_sel, and the FSM SHALL move to REQ.
REQ-005 stall SHALL be 1 in IDLE when valid&dmemen, 1 in REQ and WAIT_R, and 0 in DONE.
REQ-006 mem_req SHALL be 1 only in REQ, and mem_addr/mem_we/mem_wdata SHALL be held stable until mem_gnt.
REQ-007 mem_we SHALL be latched dmemwe<<addr[1:0]; mem_wdata SHALL be wdata<<(8*addr[1:0]); for loads mem_we SHALL be 0000.
REQ-008 In REQ with mem_gnt: a store SHALL go to DONE and a load SHALL go to WAIT_R.
REQ-009 mem_rvalid SHALL be honoured only in WAIT_R, earliest the cycle after mem_gnt; on mem_rvalid the FSM SHALL go to DONE and register rdata.
REQ-010 Load extraction SHALL take the byte or half at offset addr[1:0] of mem_rdata; LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, and LW SHALL pass the word.
REQ-011 rdata_valid SHALL be 1 only in DONE for loads; rdata SHALL hold its value until the next load completes.
REQ-012 DONE SHALL always return to IDLE, and the instruction still presented in DONE SHALL NOT be re-accepted.
REQ-013 Minimum latency SHALL be: store accepted at C0, mem_req at C1 (gnt), DONE at C2; load accepted at C0, gnt at C1, rvalid at C2, DONE at C3.
REQ-014 dmemwe values other than 0001/0011/1111/0000, or LD_sel 0000 on a load, SHALL complete as a no-op with mem_we=0000 and rdata=0.
REQ-015 Simultaneous mem_gnt and mem_rvalid in REQ SHALL ignore mem_rvalid.

Reset
REQ-016 rst SHALL force IDLE, and set stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, rdata_valid=0, misalign_err=0.
REQ-017 rst asserted mid-transaction SHALL abandon the access, and any later mem_gnt/mem_rvalid SHALL be ignored until a new request.

Configuration
REQ-018 With LSU_MISALIGN_TRAP_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL NOT assert mem_req, SHALL pulse misalign_err in the cycle after acceptance, and SHALL pass through DONE with rdata unchanged and rdata_valid=0.
REQ-019 Without LSU_MISALIGN_TRAP_EN, misalign_err SHALL be tied 0, the access SHALL be issued, and bytes shifted past lane 3 SHALL be dropped.

Verification
REQ-020 SW: addr=0x104, wdata=0xDEADBEEF, gnt at C1 -> mem_addr=0x104, mem_we=1111, mem_wdata=0xDEADBEEF; stall=1 at C0-C1, 0 at C2.
REQ-021 SB: addr=0x203, wdata=0x000000A5 -> mem_we=1000, mem_wdata[31:24]=0xA5, mem_addr=0x200.
REQ-022 Load with mem_rdata=0x80FF7F01: LB at addr 0x2 -> rdata=0xFFFFFFFF; LBU at 0x3 -> 0x00000080; LH at 0x0 -> 0x00007F01.
REQ-023 Bus back-pressure: mem_gnt held low for 5 cycles -> mem_req and all bus outputs remain stable and stall=1 throughout.
REQ-024 Reset: rst in WAIT_R, then mem_rvalid -> rdata_valid stays 0 and stall=0.
REQ-025 LW at addr 0x102: with the macro -> misalign_err pulse and no mem_req; without it -> mem_addr=0x100 and mem_req asserted.
